// File: rtl/psum_drain.sv
// psum_drain: pops finished partial-sum rows from the output FIFO
// and writes or accumulates them into the psum SRAM, with optional ReLU.
module psum_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw:0]       num_rows,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic                   acc_mode,
  input  logic                   relu_en,
  input  logic                   ofifo_valid,
  output logic                   ofifo_rd,
  input  logic [psum_bw*col-1:0] ofifo_out,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [addr_bw-1:0]     sram_addr,
  output logic [psum_bw*col-1:0] sram_d,
  input  logic [psum_bw*col-1:0] sram_q,
  output logic                   busy,
  output logic                   done
);

  localparam int W = psum_bw * col;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WR,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [addr_bw:0]     r;
  logic [addr_bw:0]     n_q;
  logic [addr_bw-1:0]   base_q;
  logic                 acc_q;
  logic                 relu_q;
  logic [W-1:0]         q_reg;
  logic [addr_bw-1:0]   row_addr;
  logic [W-1:0]         result;
  logic                 last_row;

  assign row_addr = base_q + r[addr_bw-1:0];
  assign last_row = (r + 1'b1) == n_q;

  // per-lane saturating add and ReLU clamp; lanes never interact
  for (genvar i = 0; i < col; i++) begin : g_lane
    logic signed [psum_bw-1:0] qa;
    logic signed [psum_bw-1:0] fa;
    logic signed [psum_bw:0]   sum;
    logic signed [psum_bw-1:0] sat;
    logic signed [psum_bw-1:0] s;

    assign qa  = q_reg[i*psum_bw +: psum_bw];
    assign fa  = ofifo_out[i*psum_bw +: psum_bw];
    assign sum = {qa[psum_bw-1], qa} + {fa[psum_bw-1], fa};
    assign sat = (sum[psum_bw] != sum[psum_bw-1])
               ? {sum[psum_bw], {(psum_bw-1){~sum[psum_bw]}}}
               : sum[psum_bw-1:0];
    assign s   = acc_q ? sat : fa;
    assign result[i*psum_bw +: psum_bw] =
      (relu_q && s[psum_bw-1]) ? '0 : s;
  end

  // state register, tile parameters, row counter and read capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      r      <= '0;
      n_q    <= '0;
      base_q <= '0;
      acc_q  <= 1'b0;
      relu_q <= 1'b0;
      q_reg  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_q    <= num_rows;
            base_q <= base_addr;
            acc_q  <= acc_mode;
            relu_q <= relu_en;
            r      <= '0;
          end
        end
        WAIT:    q_reg <= sram_q;
        WR:      r <= r + 1'b1;
        default: ;
      endcase
    end
  end

  // next state and outputs; everything idles while reset is high
  always_comb begin
    state_nx  = state;
    ofifo_rd  = 1'b0;
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_addr = '0;
    sram_d    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    if (!reset) begin
      busy = (state != IDLE);
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nx = (num_rows == '0) ? DONE : REQ;
          end
        end
        REQ: begin
          if (ofifo_valid) begin
            ofifo_rd = 1'b1;
            state_nx = WAIT;
            if (acc_q) begin
              sram_cen  = 1'b0;
              sram_addr = row_addr;
            end
          end
        end
        WAIT: state_nx = WR;
        WR: begin
          sram_cen  = 1'b0;
          sram_wen  = 1'b0;
          sram_addr = row_addr;
          sram_d    = result;
          state_nx  = last_row ? DONE : REQ;
        end
        DONE: begin
          done     = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed bench for psum_drain with a behavioural
// FIFO (two-cycle pop latency) and a one-cycle-latency SRAM.
module tb_psum_drain;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [11:0]  num_rows;
  logic [10:0]  base_addr;
  logic         acc_mode;
  logic         relu_en;
  logic         ofifo_valid;
  logic         ofifo_rd;
  logic [127:0] ofifo_out;
  logic         sram_cen;
  logic         sram_wen;
  logic [10:0]  sram_addr;
  logic [127:0] sram_d;
  logic [127:0] sram_q;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  psum_drain dut (
    .clk(clk), .reset(reset), .start(start),
    .num_rows(num_rows), .base_addr(base_addr),
    .acc_mode(acc_mode), .relu_en(relu_en),
    .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
    .ofifo_out(ofifo_out), .sram_cen(sram_cen),
    .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_d(sram_d), .sram_q(sram_q),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM model with a bench-side preload port
  logic [127:0] mem [0:2047];
  logic         pl_we = 1'b0;
  logic [10:0]  pl_addr = '0;
  logic [127:0] pl_data = '0;
  initial sram_q = '0;
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (!sram_cen) begin
      if (sram_wen) sram_q <= mem[sram_addr];
      else mem[sram_addr] <= sram_d;
    end
  end

  // FIFO model: row popped in cycle N is on ofifo_out in N+2
  logic [127:0] fmem [0:15];
  logic [3:0]   wp = '0;
  logic [3:0]   rp = '0;
  logic [127:0] st1 = '0;
  initial ofifo_out = '0;
  always @(posedge clk) begin
    if (ofifo_rd) begin
      st1 <= fmem[rp];
      rp  <= rp + 4'd1;
    end
    ofifo_out <= st1;
  end

  // activity counters
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, acc_cnt = 0, done_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ofifo_rd) rd_cnt <= rd_cnt + 1;
    if (!sram_cen && !sram_wen) wr_cnt <= wr_cnt + 1;
    if (!sram_cen) acc_cnt <= acc_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [127:0] rowv(
    input int a0, input int a1, input int a2, input int a3,
    input int a4, input int a5, input int a6, input int a7);
    return {a7[15:0], a6[15:0], a5[15:0], a4[15:0],
            a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  task automatic push(input logic [127:0] v);
    fmem[wp] = v;
    wp = wp + 4'd1;
  endtask

  task automatic poke(input int a, input logic [127:0] d);
    pl_addr = a[10:0];
    pl_data = d;
    pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic start_tile(input int n, input int b,
    input logic acc, input logic relu, output int t0);
    num_rows = n[11:0];
    base_addr = b[10:0];
    acc_mode = acc;
    relu_en = relu;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, output int dc);
    dc = -1;
    for (int k = 0; k < 200; k++) begin
      if (done === 1'b1) begin
        dc = cyc - t0 + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    num_rows = '0;
    base_addr = '0;
    acc_mode = 1'b0;
    relu_en = 1'b0;
    ofifo_valid = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if ({ofifo_rd, sram_cen, sram_wen, busy, done} !== 5'b01100) begin
        failures++;
        $display("FAIL reset_ctl%0d got=%b exp=01100", p,
          {ofifo_rd, sram_cen, sram_wen, busy, done});
      end
      checks++;
      if (sram_addr !== 11'd0) begin
        failures++;
        $display("FAIL reset_addr%0d got=%0d exp=0", p, sram_addr);
      end
      checks++;
      if (sram_d !== 128'd0) begin
        failures++;
        $display("FAIL reset_d%0d got=%h exp=0", p, sram_d);
      end
      reset = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_overwrite;
    logic [127:0] ex [4];
    int t0, dc, rd0, wr0, ac0;
    ex[0] = rowv(1, 2, 3, 4, 5, 6, 7, 8);
    ex[1] = rowv(-1, -2, -3, -4, 100, 200, 300, 400);
    ex[2] = rowv(32767, -32768, 0, 1, -1, 9, 99, 999);
    ex[3] = rowv(4660, 22136, -21555, 0, 0, 0, 0, -7);
    for (int i = 0; i < 4; i++) begin
      poke(10 + i, {8{16'hdead}});
      push(ex[i]);
    end
    ofifo_valid = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt; ac0 = acc_cnt;
    start_tile(4, 10, 1'b0, 1'b0, t0);
    wait_done(t0, dc);
    checks++;
    if (dc !== 13) begin
      failures++;
      $display("FAIL ovw_done_cycle got=%0d exp=13", dc);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL ovw_after_done got=%b exp=00", {done, busy});
    end
    checks++;
    if (rd_cnt - rd0 !== 4) begin
      failures++;
      $display("FAIL ovw_pops got=%0d exp=4", rd_cnt - rd0);
    end
    checks++;
    if (acc_cnt - ac0 !== 4 || wr_cnt - wr0 !== 4) begin
      failures++;
      $display("FAIL ovw_sram_ops got=%0d/%0d exp=4/4",
        acc_cnt - ac0, wr_cnt - wr0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[10 + i] !== ex[i]) begin
        failures++;
        $display("FAIL ovw_row%0d got=%h exp=%h", i, mem[10 + i], ex[i]);
      end
    end
  endtask

  task automatic test_accumulate;
    logic [127:0] e0, e1;
    int t0, dc, ac0;
    poke(20, rowv(100, 32767, -32768, 0, -100, 1234, -1, 16384));
    poke(21, rowv(-20000, 20000, 0, 0, 0, 0, 0, 0));
    push(rowv(-30, 5, -1, 0, -1, -234, 1, 16384));
    push(rowv(-20000, -20000, 5, -5, 0, 0, 0, 0));
    e0 = rowv(70, 32767, -32768, 0, -101, 1000, 0, 32767);
    e1 = rowv(-32768, 0, 5, -5, 0, 0, 0, 0);
    ac0 = acc_cnt;
    start_tile(2, 20, 1'b1, 1'b0, t0);
    wait_done(t0, dc);
    checks++;
    if (dc !== 7) begin
      failures++;
      $display("FAIL acc_done_cycle got=%0d exp=7", dc);
    end
    @(negedge clk);
    checks++;
    if (acc_cnt - ac0 !== 4) begin
      failures++;
      $display("FAIL acc_sram_ops got=%0d exp=4", acc_cnt - ac0);
    end
    checks++;
    if (mem[20] !== e0) begin
      failures++;
      $display("FAIL acc_row0 got=%h exp=%h", mem[20], e0);
    end
    checks++;
    if (mem[21] !== e1) begin
      failures++;
      $display("FAIL acc_row1 got=%h exp=%h", mem[21], e1);
    end
  endtask

  task automatic test_relu;
    logic [127:0] e0, e1;
    int t0, dc;
    poke(30, rowv(10, 10, -5, 100, 7, -1, 32767, -32768));
    push(rowv(-25, 25, 3, -200, 0, 2, 1, -1));
    e0 = rowv(0, 35, 0, 0, 7, 1, 32767, 0);
    start_tile(1, 30, 1'b1, 1'b1, t0);
    wait_done(t0, dc);
    checks++;
    if (dc !== 4) begin
      failures++;
      $display("FAIL relu_acc_done got=%0d exp=4", dc);
    end
    @(negedge clk);
    checks++;
    if (mem[30] !== e0) begin
      failures++;
      $display("FAIL relu_acc_row got=%h exp=%h", mem[30], e0);
    end
    push(rowv(-1, 1, -32768, 32767, 0, -7, 7, -100));
    e1 = rowv(0, 1, 0, 32767, 0, 0, 7, 0);
    start_tile(1, 31, 1'b0, 1'b1, t0);
    wait_done(t0, dc);
    @(negedge clk);
    checks++;
    if (mem[31] !== e1) begin
      failures++;
      $display("FAIL relu_ovw_row got=%h exp=%h", mem[31], e1);
    end
  endtask

  task automatic test_stall;
    logic [127:0] ex [3];
    int t0, dc, rd0;
    ex[0] = rowv(11, 12, 13, 14, 15, 16, 17, 18);
    ex[1] = rowv(-11, -12, -13, -14, -15, -16, -17, -18);
    ex[2] = rowv(500, 0, 500, 0, 500, 0, 500, 0);
    for (int i = 0; i < 3; i++) push(ex[i]);
    rd0 = rd_cnt;
    start_tile(3, 40, 1'b0, 1'b0, t0);
    for (int k = 0; k < 20; k++) begin
      if (!sram_cen && !sram_wen) break;
      @(negedge clk);
    end
    ofifo_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (ofifo_rd !== 1'b0 || sram_cen !== 1'b1) begin
        failures++;
        $display("FAIL stall%0d rd/cen got=%b%b exp=01",
          k, ofifo_rd, sram_cen);
      end
      if (k == 2) begin
        num_rows = 12'd1;
        base_addr = 11'd100;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    ofifo_valid = 1'b1;
    wait_done(t0, dc);
    checks++;
    if (dc !== 15) begin
      failures++;
      $display("FAIL stall_done_cycle got=%0d exp=15", dc);
    end
    @(negedge clk);
    checks++;
    if (rd_cnt - rd0 !== 3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_pops got=%0d busy=%b exp=3 0",
        rd_cnt - rd0, busy);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[40 + i] !== ex[i]) begin
        failures++;
        $display("FAIL stall_row%0d got=%h exp=%h", i, mem[40 + i], ex[i]);
      end
    end
  endtask

  task automatic test_wrap_zero;
    logic [127:0] ex [3];
    logic [127:0] mk;
    int t0, dc, rd0, ac0;
    mk = {8{16'h5a5a}};
    poke(1, mk);
    ex[0] = rowv(21, 22, 23, 24, 25, 26, 27, 28);
    ex[1] = rowv(31, 32, 33, 34, 35, 36, 37, 38);
    ex[2] = rowv(41, 42, 43, 44, 45, 46, 47, 48);
    for (int i = 0; i < 3; i++) push(ex[i]);
    start_tile(3, 2046, 1'b0, 1'b0, t0);
    wait_done(t0, dc);
    checks++;
    if (dc !== 10) begin
      failures++;
      $display("FAIL wrap_done_cycle got=%0d exp=10", dc);
    end
    @(negedge clk);
    checks++;
    if (mem[2046] !== ex[0] || mem[2047] !== ex[1]) begin
      failures++;
      $display("FAIL wrap_top got=%h %h", mem[2046], mem[2047]);
    end
    checks++;
    if (mem[0] !== ex[2] || mem[1] !== mk) begin
      failures++;
      $display("FAIL wrap_low got=%h %h exp=%h %h",
        mem[0], mem[1], ex[2], mk);
    end
    rd0 = rd_cnt; ac0 = acc_cnt;
    start_tile(0, 5, 1'b1, 1'b0, t0);
    checks++;
    if ({busy, done} !== 2'b11) begin
      failures++;
      $display("FAIL zero_done got=%b exp=11", {busy, done});
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || rd_cnt != rd0 || acc_cnt != ac0) begin
      failures++;
      $display("FAIL zero_quiet bd=%b pops=%0d ops=%0d exp=00 0 0",
        {busy, done}, rd_cnt - rd0, acc_cnt - ac0);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] ex [4];
    logic [127:0] mk;
    int t0, dc, rd0, wr0, dn0;
    mk = {8{16'hbeef}};
    ex[0] = rowv(61, 62, 63, 64, 65, 66, 67, 68);
    ex[1] = rowv(71, 72, 73, 74, 75, 76, 77, 78);
    ex[2] = rowv(81, 82, 83, 84, 85, 86, 87, 88);
    ex[3] = rowv(91, 92, 93, 94, 95, 96, 97, 98);
    for (int i = 0; i < 4; i++) begin
      poke(50 + i, mk);
      push(ex[i]);
    end
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    start_tile(4, 50, 1'b0, 1'b0, t0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({ofifo_rd, sram_cen, sram_wen, busy, done} !== 5'b01100 ||
        sram_addr !== 11'd0 || sram_d !== 128'd0) begin
      failures++;
      $display("FAIL rstmid_outs got=%b exp=01100",
        {ofifo_rd, sram_cen, sram_wen, busy, done});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({ofifo_rd, sram_cen, sram_wen, busy, done} !== 5'b01100) begin
      failures++;
      $display("FAIL rstmid_after got=%b exp=01100",
        {ofifo_rd, sram_cen, sram_wen, busy, done});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rd_cnt - rd0 !== 3 || wr_cnt - wr0 !== 2 || done_cnt != dn0) begin
      failures++;
      $display("FAIL rstmid_activity pops=%0d wr=%0d dn=%0d exp=3 2 0",
        rd_cnt - rd0, wr_cnt - wr0, done_cnt - dn0);
    end
    checks++;
    if (mem[50] !== ex[0] || mem[51] !== ex[1]) begin
      failures++;
      $display("FAIL rstmid_done_rows got=%h %h", mem[50], mem[51]);
    end
    checks++;
    if (mem[52] !== mk || mem[53] !== mk) begin
      failures++;
      $display("FAIL rstmid_untouched got=%h %h", mem[52], mem[53]);
    end
    wp = rp;
    push(ex[2]);
    push(ex[3]);
    start_tile(2, 60, 1'b0, 1'b0, t0);
    wait_done(t0, dc);
    checks++;
    if (dc !== 7) begin
      failures++;
      $display("FAIL rstmid_restart_done got=%0d exp=7", dc);
    end
    @(negedge clk);
    checks++;
    if (mem[60] !== ex[2] || mem[61] !== ex[3]) begin
      failures++;
      $display("FAIL rstmid_restart_rows got=%h %h", mem[60], mem[61]);
    end
  endtask

  initial begin
    test_reset;
    test_overwrite;
    test_accumulate;
    test_relu;
    test_stall;
    test_wrap_zero;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
